// File: rtl/demux_router_pkg.sv
// demux_router_pkg: default widths and port-select constants for demux_router
package demux_router_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register with load, drain and valid flag
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    always_ff @(posedge clk) begin
        valid <= rst ? 1'b0 : load ? 1'b1 : (valid && ready) ? 1'b0 : valid;
        data  <= rst ? '0 : load ? ld_data : data;
    end
endmodule

// File: rtl/demux_router.sv
// demux_router: routes each input word to port a or b; DEMUX_ROUTER_COUNT_EN enables transfer counters
module demux_router
    import demux_router_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    logic load_a, load_b;
    always_comb begin
        in_ready = !rst && ((in_sel == PORT_B) ? (!b_valid || b_ready) : (!a_valid || a_ready));
        load_a   = in_valid && in_ready && (in_sel == PORT_A);
        load_b   = in_valid && in_ready && (in_sel == PORT_B);
    end
    demux_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk(clk), .rst(rst), .load(load_a), .ld_data(in_data),
        .ready(a_ready), .valid(a_valid), .data(a_data)
    );
    demux_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk(clk), .rst(rst), .load(load_b), .ld_data(in_data),
        .ready(b_ready), .valid(b_valid), .data(b_data)
    );
`ifdef DEMUX_ROUTER_COUNT_EN
    always_ff @(posedge clk) begin
        cnt_a <= rst ? '0 : cnt_a + CNT_W'(a_valid && a_ready);
        cnt_b <= rst ? '0 : cnt_b + CNT_W'(b_valid && b_ready);
    end
`else
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif
endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: randomized and directed scoreboard bench for demux_router
module tb_demux_router;
    logic       clk = 1'b0;
    logic       rst, in_sel, in_valid, in_ready;
    logic [7:0] in_data, a_data, b_data, cnt_a, cnt_b;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [7:0] qa[$], qb[$];
    logic [7:0] la = 8'h00, lb = 8'h00, ca = 8'h00, cb = 8'h00;
    logic       exp_rdy = 1'b0;
    bit         started = 1'b0;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    demux_router #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", n, $time, act, exp);
        end
    endtask

    // Monitor: compares against the model's pending words, retires transfers
    always @(negedge clk) if (started) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("a_valid", {31'd0, a_valid}, {31'd0, qa.size() > 0});
        chk("b_valid", {31'd0, b_valid}, {31'd0, qb.size() > 0});
        chk("a_data", {24'd0, a_data}, {24'd0, (qa.size() > 0) ? qa[0] : la});
        chk("b_data", {24'd0, b_data}, {24'd0, (qb.size() > 0) ? qb[0] : lb});
`ifdef DEMUX_ROUTER_COUNT_EN
        chk("cnt_a", {24'd0, cnt_a}, {24'd0, ca});
        chk("cnt_b", {24'd0, cnt_b}, {24'd0, cb});
`else
        chk("cnt_a", {24'd0, cnt_a}, 32'd0);
        chk("cnt_b", {24'd0, cnt_b}, 32'd0);
`endif
        if (rst) begin
            qa.delete(); qb.delete();
            la = 8'h00; lb = 8'h00; ca = 8'h00; cb = 8'h00;
        end else begin
            if (qa.size() > 0 && a_ready) begin la = qa.pop_front(); ca = ca + 8'd1; end
            if (qb.size() > 0 && b_ready) begin lb = qb.pop_front(); cb = cb + 8'd1; end
        end
    end

    // Stimulus: drives one cycle and pushes the accepted word into its port queue
    task automatic cyc(input logic r, input logic v, input logic s, input logic [7:0] d,
                       input logic ar, input logic br);
        rst = r; in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
        exp_rdy = !r && (s ? (qb.size() == 0 || br) : (qa.size() == 0 || ar));
        @(posedge clk);
        if (v && exp_rdy) begin
            if (s) qb.push_back(d);
            else qa.push_back(d);
        end
        started = 1'b1;
        #1;
    endtask

    initial begin
        repeat (2) cyc(1, 1, 0, 8'hAA, 1, 1);
        cyc(0, 1, 0, 8'h5A, 0, 0);
        repeat (3) cyc(0, 0, 0, 8'hFF, 0, 0);
        cyc(0, 1, 0, 8'h77, 0, 0);
        cyc(0, 1, 1, 8'h33, 0, 0);
        repeat (2) cyc(0, 0, 1, 8'h00, 1, 1);
        for (int i = 1; i <= 8; i++) cyc(0, 1, 1, 8'(i), 0, 1);
        repeat (2) cyc(0, 0, 0, 8'h00, 0, 1);
        cyc(0, 1, 0, 8'h11, 0, 0);
        cyc(0, 1, 0, 8'h22, 1, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        cyc(0, 1, 1, 8'h44, 0, 0);
        cyc(1, 1, 0, 8'h99, 1, 1);
        cyc(0, 0, 0, 8'h00, 1, 1);
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 8'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        repeat (3) cyc(0, 0, 0, 8'h00, 1, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux_router.md
DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 Parameter WIDTH, default 8, data bit width of all data ports.
REQ-002 Parameter CNT_W, default 8, width of each transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  WIDTH  word to be routed.
REQ-006 in_sel  input  1  destination: 0 -> port a, 1 -> port b.
REQ-007 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 in_ready  output  1  router accepts the word this cycle.
REQ-009 a_data, b_data  output  WIDTH  routed word per port.
REQ-010 a_valid, b_valid  output  1  per-port word present.
REQ-011 a_ready, b_ready  input  1  per-port consumer accepts.
REQ-012 cnt_a, cnt_b  output  CNT_W  completed output transfers per port.

Function
REQ-013 Input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; output transfer on x_valid=1 and x_ready=1.
REQ-014 Each port SHALL own a one-entry holding slot (valid flag plus data register).
REQ-015 in_ready SHALL be 1 iff rst=0 and the slot selected by in_sel is empty or is draining this cycle (x_valid=1 and x_ready=1).
REQ-016 in_ready SHALL depend only on the selected slot; a full unselected slot has no effect.
REQ-017 An accepted word SHALL appear on the selected port's x_data with x_valid=1 on the next cycle (latency 1); the other slot is unchanged.
REQ-018 With x_valid=1 and x_ready=0, x_data and x_valid SHALL hold stable.
REQ-019 Drain without load: x_valid goes 0 next cycle; x_data retains its last value.
REQ-020 Drain and load of the same slot in one cycle: x_valid stays 1, x_data takes the new word next cycle; back-to-back rate is one word per cycle.
REQ-021 Both slots SHALL drain independently and concurrently.
REQ-022 in_data and in_sel SHALL be ignored when in_valid=0.

Reset
REQ-023 With rst=1 at a rising edge: a_valid=b_valid=0, a_data=b_data=0, cnt_a=cnt_b=0.
REQ-024 in_ready SHALL be 0 during any cycle with rst=1.
REQ-025 Reset mid-operation SHALL discard held words without an output transfer or counter increment.

Configuration
REQ-026 Macro DEMUX_ROUTER_COUNT_EN: when defined, cnt_a/cnt_b increment by 1 on each a/b output transfer, wrapping from 2^CNT_W-1 to 0.
REQ-027 Without DEMUX_ROUTER_COUNT_EN: cnt_a and cnt_b remain present and SHALL be driven constant 0; no counter registers are built.

Structure
REQ-028 Package demux_router_pkg SHALL hold the default WIDTH/CNT_W constants and the port-select constants PORT_A=0, PORT_B=1.
REQ-029 Sub-module demux_slot (one-entry holding register with load/drain/valid) SHALL be instantiated once per port.

Verification
REQ-030 Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, both valids 0, counters 0.
REQ-031 Route: in_data=0x5A, in_sel=0, a_ready=0 -> next cycle a_valid=1, a_data=0x5A, b_valid=0; held stable 3 cycles; in_sel=0 in_ready=0, in_sel=1 in_ready=1.
REQ-032 Streaming: 0x01..0x08 on in_sel=1 with b_ready=1 -> b_data 0x01..0x08 on consecutive cycles, in_ready=1 throughout, cnt_b=8 (macro on).
REQ-033 Simultaneous: a holds 0x11, a_ready=1, in_data=0x22 in_sel=0 -> in_ready=1; next cycle a_valid=1, a_data=0x22, cnt_a+1.
REQ-034 Wrap: CNT_W=2, 5 transfers on port a -> cnt_a sequence 1,2,3,0,1; with macro off cnt_a=0 always.
REQ-035 Mid-op reset: a and b both full, assert rst -> next cycle both valids 0, counters unchanged by the discarded words, then 0.
